qam16_frame_scheduler: RTL
==========================

QAM16_FRAME_SCHEDULER -- requirements
Module: qam16_frame_scheduler

Interface
REQ-001 SHALL have parameter PREAMBLE_WORD, default 32'hF0F0_F0F0, the 32-bit word sent in each preamble slot.
REQ-002 SHALL have parameter PREAMBLE_LEN, default 2, the number of preamble words per frame (range 1..15).
REQ-003 SHALL have parameter MAX_PAYLOAD, default 16, the payload buffer depth in 32-bit words (range 1..255).
REQ-004 SHALL have parameter GAP_CYCLES, default 4, the number of idle cycles after each frame (range 0..255).
REQ-005 SHALL have port aclk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port enable  input  1  permits start of a new frame.
REQ-008 SHALL have port s_axis_tdata  input  32  payload word from source.
REQ-009 SHALL have port s_axis_tvalid  input  1  source word valid.
REQ-010 SHALL have port s_axis_tlast  input  1  last payload word of frame.
REQ-011 SHALL have port s_axis_tready  output  1  scheduler accepts a payload word.
REQ-012 SHALL have port m_axis_tdata  output  32  word to the QAM16 data packetizer.
REQ-013 SHALL have port m_axis_tvalid  output  1  m_axis_tdata valid.
REQ-014 SHALL have port m_axis_tready  input  1  packetizer accepts word.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port overflow_err  output  1  sticky flag, payload exceeded MAX_PAYLOAD.
REQ-017 SHALL have port frame_count  output  16  frames fully transmitted, wraps 16'hFFFF->0.

Function
REQ-018 SHALL implement states IDLE, COLLECT, DRAIN, PREAMBLE, HEADER, PAYLOAD, GAP.
REQ-019 SHALL transfer on either AXI-stream port only when tvalid and tready are both high in the same cycle.
REQ-020 SHALL drive s_axis_tready high only in COLLECT and DRAIN, and in IDLE when enable is high.
REQ-021 SHALL, in IDLE with enable high, store an accepted word at buffer index 0 and go to COLLECT, or go directly to PREAMBLE if tlast is also high.
REQ-022 SHALL, in COLLECT, store each accepted word at the next buffer index and count words in len (8 bit).
REQ-023 SHALL go from COLLECT to PREAMBLE in the cycle after accepting a word with tlast high.
REQ-024 SHALL, when the buffer holds MAX_PAYLOAD words and tlast is not yet received, set overflow_err and go to DRAIN.
REQ-025 SHALL, in DRAIN, accept and discard words until tlast is accepted, then go to PREAMBLE with len = MAX_PAYLOAD.
REQ-026 SHALL, in PREAMBLE, emit PREAMBLE_WORD PREAMBLE_LEN times and then go to HEADER.
REQ-027 SHALL, in HEADER, emit {8'h5A, seq[7:0], 8'h00, len[7:0]} once and then go to PAYLOAD.
REQ-028 SHALL, in PAYLOAD, emit buffer words 0..len-1 in order and then go to GAP.
REQ-029 SHALL assert m_axis_tvalid in the first cycle of PREAMBLE, which is the cycle after the last payload word was accepted.
REQ-030 SHALL hold m_axis_tdata and m_axis_tvalid stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-031 SHALL advance to the next word on the same cycle as the handshake, so that back-to-back words are sent with no bubble while tready stays high.
REQ-032 SHALL keep m_axis_tvalid low outside PREAMBLE, HEADER and PAYLOAD.
REQ-033 SHALL, on the handshake of the last payload word, increment seq (8 bit, wraps 255->0) and frame_count.
REQ-034 SHALL stay in GAP for exactly GAP_CYCLES cycles (0 means go directly to IDLE) and then go to IDLE.
REQ-035 SHALL ignore enable once a frame has started; when enable is low the current frame completes and the block then waits in IDLE.
REQ-036 SHALL clear overflow_err only on reset.

Reset
REQ-037 SHALL, on reset, set state=IDLE, m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=0, busy=0, overflow_err=0, frame_count=0, seq=0 and len=0.
REQ-038 SHALL abort any frame in progress on reset, discarding buffered payload; the buffer contents need no reset.

Verification
REQ-039 SHALL cover: enable=1, m_axis_tready=1, 3 words 11,22,33 (33 with tlast) -> F0F0F0F0, F0F0F0F0, 5A000003, 11, 22, 33 on consecutive cycles; frame_count=1.
REQ-040 SHALL cover: 20 words with tlast on the 20th -> overflow_err=1, header 5A000010, exactly 16 payload words sent.
REQ-041 SHALL cover: m_axis_tready toggling 1/0 every cycle -> no word lost or duplicated, and data held while tready=0.
REQ-042 SHALL cover: two single-word frames -> headers 5A000001 then 5A010001, with at least 4 idle cycles between frames.
REQ-043 SHALL cover: resetn low during PAYLOAD -> next cycle m_axis_tvalid=0, busy=0, frame_count=0; the next frame starts with seq 00.
REQ-044 SHALL cover: enable=0 with s_axis_tvalid=1 in IDLE -> s_axis_tready=0 and no output.

Source files
------------

// File: rtl/qam16_frame_scheduler.sv
// Frame scheduler for the QAM16 packetizer: buffers one payload frame, then sends
// preamble words, a header word and the buffered payload, followed by an idle gap.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for enable and the first payload word
// COLLECT  | storing payload words until tlast
// DRAIN    | buffer full, discarding words until tlast
// PREAMBLE | sending PREAMBLE_WORD PREAMBLE_LEN times
// HEADER   | sending {5A, seq, 00, len}
// PAYLOAD  | sending buffered words 0..len-1
// GAP      | GAP_CYCLES idle cycles before returning to IDLE
module qam16_frame_scheduler #(
  parameter logic [31:0] PREAMBLE_WORD = 32'hF0F0_F0F0,
  parameter int          PREAMBLE_LEN  = 2,
  parameter int          MAX_PAYLOAD   = 16,
  parameter int          GAP_CYCLES    = 4
) (
  input  logic        aclk,
  input  logic        resetn,
  input  logic        enable,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        busy,
  output logic        overflow_err,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_DRAIN, S_PREAMBLE, S_HEADER, S_PAYLOAD, S_GAP
  } state_t;

  localparam int         AW       = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [7:0] MAX_LEN  = 8'(MAX_PAYLOAD);
  localparam logic [3:0] PRE_LOAD = 4'(PREAMBLE_LEN - 1);
  localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t      state, state_nxt;
  logic [31:0] pay_mem [0:(1<<AW)-1];
  logic [7:0]  len;
  logic [7:0]  rd_idx;
  logic [7:0]  gap_cnt;
  logic [7:0]  seq;
  logic [3:0]  pre_cnt;
  logic        s_hs, m_hs, last_pay;

  assign s_hs     = s_axis_tvalid && s_axis_tready;
  assign m_hs     = m_axis_tvalid && m_axis_tready;
  assign last_pay = (rd_idx == len - 8'd1);

  always_ff @(posedge aclk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (s_hs) begin
          if (s_axis_tlast)          state_nxt = S_PREAMBLE;
          else if (MAX_LEN == 8'd1)  state_nxt = S_DRAIN;
          else                       state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (s_hs) begin
          if (s_axis_tlast)                 state_nxt = S_PREAMBLE;
          else if (len == MAX_LEN - 8'd1)   state_nxt = S_DRAIN;
        end
      end
      S_DRAIN:    if (s_hs && s_axis_tlast)     state_nxt = S_PREAMBLE;
      S_PREAMBLE: if (m_hs && pre_cnt == 4'd0)  state_nxt = S_HEADER;
      S_HEADER:   if (m_hs)                     state_nxt = S_PAYLOAD;
      S_PAYLOAD:  if (m_hs && last_pay)         state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      S_GAP:      if (gap_cnt == 8'd0)          state_nxt = S_IDLE;
      default:                                  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 32'd0;
    busy          = (state != S_IDLE);
    case (state)
      S_IDLE:    s_axis_tready = resetn && enable;
      S_COLLECT,
      S_DRAIN:   s_axis_tready = resetn;
      S_PREAMBLE: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = PREAMBLE_WORD;
      end
      S_HEADER: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = {8'h5A, seq, 8'h00, len};
      end
      S_PAYLOAD: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = pay_mem[rd_idx[AW-1:0]];
      end
      default: ;
    endcase
  end

  // Payload buffer carries no reset; len alone defines which entries are valid.
  always_ff @(posedge aclk) begin
    if (s_hs && state == S_IDLE)    pay_mem[0]             <= s_axis_tdata;
    if (s_hs && state == S_COLLECT) pay_mem[len[AW-1:0]]   <= s_axis_tdata;
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      len          <= 8'd0;
      seq          <= 8'd0;
      frame_count  <= 16'd0;
      overflow_err <= 1'b0;
      rd_idx       <= 8'd0;
      pre_cnt      <= PRE_LOAD;
      gap_cnt      <= GAP_LOAD;
    end else begin
      if (s_hs && state == S_IDLE)                   len <= 8'd1;
      if (s_hs && state == S_COLLECT)                len <= len + 8'd1;
      if (s_hs && state == S_DRAIN && s_axis_tlast)  len <= MAX_LEN;

      if (state != S_DRAIN && state_nxt == S_DRAIN)  overflow_err <= 1'b1;

      if (state != S_PREAMBLE) pre_cnt <= PRE_LOAD;
      else if (m_hs)           pre_cnt <= pre_cnt - 4'd1;

      if (state != S_PAYLOAD)  rd_idx <= 8'd0;
      else if (m_hs)           rd_idx <= rd_idx + 8'd1;

      if (state != S_GAP)      gap_cnt <= GAP_LOAD;
      else                     gap_cnt <= gap_cnt - 8'd1;

      if (state == S_PAYLOAD && m_hs && last_pay) begin
        seq         <= seq + 8'd1;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule
